// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the binary-neural-network responder family.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HID  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } bnn_state_t;

  // Bits needed for a pre-activation sum that cannot overflow.
  function automatic int pre_width(input int feat_cnt, input int feat_bits);
    return $clog2(feat_cnt * ((1 << feat_bits) - 1) + 1);
  endfunction

  function automatic int score_width(input int hidden_cnt);
    return $clog2(hidden_cnt + 1);
  endfunction

endpackage

// File: rtl/bnn_seq_responder_if.sv
// Request/response bundle between the stimulus harness and the BNN responder.
interface bnn_seq_responder_if #(
  parameter int FEAT_CNT  = 12,
  parameter int FEAT_BITS = 4,
  parameter int CLASS_CNT = 6
);
  logic                             start;
  logic [FEAT_BITS*FEAT_CNT-1:0]    features;
  logic                             busy;
  logic                             done;
  logic [$clog2(CLASS_CNT)-1:0]     prediction;

  modport master (output start, features, input busy, done, prediction);
  modport slave  (input start, features, output busy, done, prediction);
endinterface

// File: rtl/bnn_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module bnn_popcount #(
  parameter  int WIDTH = 40,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CW-1:0]    count
);
  always_comb begin
    count = '0;
    for (int k = 0; k < WIDTH; k++) begin
      count = count + CW'(bits[k]);
    end
  end
endmodule

// File: rtl/bnn_seq_responder.sv
// Sequential BNN inference: one hidden neuron per cycle, then one class per cycle,
// reporting the argmax class with a single-cycle done pulse.
module bnn_seq_responder
  import bnn_pkg::*;
#(
  parameter int FEAT_CNT   = 12,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT  = 6,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1 = '1,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2 = '1
) (
  input logic               clk,
  input logic               rst,
  bnn_seq_responder_if.slave bus
);
  localparam int PRE_W  = pre_width(FEAT_CNT, FEAT_BITS);
  localparam int SCR_W  = score_width(HIDDEN_CNT);
  localparam int HCNT_W = $clog2(HIDDEN_CNT);
  localparam int CCNT_W = $clog2(CLASS_CNT);
  localparam int THRESH = FEAT_CNT * ((1 << FEAT_BITS) - 1);

  bnn_state_t                    state_reg, state_next;
  logic [FEAT_BITS*FEAT_CNT-1:0] feat_reg, feat_next;
  logic [HIDDEN_CNT-1:0]         hidden_reg, hidden_next;
  logic [HCNT_W-1:0]             hid_cnt_reg, hid_cnt_next;
  logic [CCNT_W-1:0]             cls_cnt_reg, cls_cnt_next;
  logic [SCR_W-1:0]              best_score_reg, best_score_next;
  logic [CCNT_W-1:0]             best_idx_reg, best_idx_next;
  logic                          busy_reg, busy_next;
  logic                          done_reg, done_next;
  logic [CCNT_W-1:0]             pred_reg, pred_next;

  logic [FEAT_CNT-1:0]   w1_row;
  logic [HIDDEN_CNT-1:0] w2_row;
  logic [FEAT_BITS-1:0]  term [FEAT_CNT];
  logic [PRE_W-1:0]      pre;
  logic [PRE_W:0]        pre_x2;
  logic                  h_bit;
  logic [SCR_W-1:0]      score;

  assign w1_row = W1[int'(hid_cnt_reg)*FEAT_CNT +: FEAT_CNT];
  assign w2_row = W2[int'(cls_cnt_reg)*HIDDEN_CNT +: HIDDEN_CNT];

  // A -1 weight contributes (2^FEAT_BITS-1 - f), which is just ~f at full width.
  for (genvar gi = 0; gi < FEAT_CNT; gi++) begin : g_term
    assign term[gi] = w1_row[gi] ? feat_reg[gi*FEAT_BITS +: FEAT_BITS]
                                 : ~feat_reg[gi*FEAT_BITS +: FEAT_BITS];
  end

  always_comb begin
    pre = '0;
    for (int i = 0; i < FEAT_CNT; i++) begin
      pre = pre + PRE_W'(term[i]);
    end
  end

  assign pre_x2 = {pre, 1'b0};
  assign h_bit  = (pre_x2 >= (PRE_W+1)'(THRESH));

  bnn_popcount #(.WIDTH(HIDDEN_CNT)) u_popcount (
    .bits  (~(hidden_reg ^ w2_row)),
    .count (score)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      feat_reg       <= '0;
      hidden_reg     <= '0;
      hid_cnt_reg    <= '0;
      cls_cnt_reg    <= '0;
      best_score_reg <= '0;
      best_idx_reg   <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      pred_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      feat_reg       <= feat_next;
      hidden_reg     <= hidden_next;
      hid_cnt_reg    <= hid_cnt_next;
      cls_cnt_reg    <= cls_cnt_next;
      best_score_reg <= best_score_next;
      best_idx_reg   <= best_idx_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      pred_reg       <= pred_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    feat_next       = feat_reg;
    hidden_next     = hidden_reg;
    hid_cnt_next    = hid_cnt_reg;
    cls_cnt_next    = cls_cnt_reg;
    best_score_next = best_score_reg;
    best_idx_next   = best_idx_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    pred_next       = pred_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          feat_next    = bus.features;
          hidden_next  = '0;
          hid_cnt_next = '0;
          cls_cnt_next = '0;
          busy_next    = 1'b1;
          state_next   = HID;
        end
      end
      HID: begin
        hidden_next[hid_cnt_reg] = h_bit;
        if (hid_cnt_reg == HCNT_W'(HIDDEN_CNT - 1)) begin
          hid_cnt_next = '0;
          state_next   = OUT;
        end else begin
          hid_cnt_next = hid_cnt_reg + 1'b1;
        end
      end
      OUT: begin
        // Strict compare keeps the lowest class index on ties.
        if (cls_cnt_reg == '0 || score > best_score_reg) begin
          best_score_next = score;
          best_idx_next   = cls_cnt_reg;
        end
        if (cls_cnt_reg == CCNT_W'(CLASS_CNT - 1)) begin
          cls_cnt_next = '0;
          busy_next    = 1'b0;
          done_next    = 1'b1;
          pred_next    = best_idx_next;
          state_next   = DONE;
        end else begin
          cls_cnt_next = cls_cnt_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.prediction = pred_reg;

endmodule

// File: tb/tb_bnn_seq_responder.sv
// Directed bench: four responders with different W2 tables, shared clock and reset.
module tb_bnn_seq_responder;
  localparam int FEAT_CNT   = 12;
  localparam int FEAT_BITS  = 4;
  localparam int HIDDEN_CNT = 40;
  localparam int CLASS_CNT  = 6;
  localparam int NDUT       = 4;
  localparam int LATENCY    = HIDDEN_CNT + CLASS_CNT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic                          start_v    [NDUT];
  logic [FEAT_BITS*FEAT_CNT-1:0] features_v [NDUT];
  logic                          busy_v     [NDUT];
  logic                          done_v     [NDUT];
  logic [2:0]                    pred_v     [NDUT];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  function automatic logic [CLASS_CNT*HIDDEN_CNT-1:0] w2_for(input int k);
    logic [CLASS_CNT*HIDDEN_CNT-1:0] w;
    w = '0;
    for (int c = 0; c < CLASS_CNT; c++) begin
      case (k)
        0: w[c*HIDDEN_CNT +: HIDDEN_CNT] = '1;
        1: if (c == 3) w[c*HIDDEN_CNT +: HIDDEN_CNT] = '1;
        2: if (c == 2 || c == 4) w[c*HIDDEN_CNT +: HIDDEN_CNT] = '1;
        default: if (c != 5) w[c*HIDDEN_CNT +: HIDDEN_CNT] = '1;
      endcase
    end
    return w;
  endfunction

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam logic [CLASS_CNT*HIDDEN_CNT-1:0] W2_G = w2_for(gi);
    bnn_seq_responder_if #(.FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS),
                           .CLASS_CNT(CLASS_CNT)) bus ();
    assign bus.start    = start_v[gi];
    assign bus.features = features_v[gi];
    assign busy_v[gi]   = bus.busy;
    assign done_v[gi]   = bus.done;
    assign pred_v[gi]   = bus.prediction;

    bnn_seq_responder #(
      .FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS),
      .HIDDEN_CNT(HIDDEN_CNT), .CLASS_CNT(CLASS_CNT),
      .W1('1), .W2(W2_G)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one request on DUT idx. alt_at: busy cycle at which a competing start
  // with inverted features is raised. rst_at: busy cycle at which reset hits.
  task automatic run_one(input string tag, input int idx,
                         input logic [FEAT_BITS*FEAT_CNT-1:0] feat,
                         input int exp_pred, input int alt_at, input int rst_at);
    int cycles = 0;
    int dones  = 0;
    bit got    = 0;
    @(negedge clk);
    features_v[idx] = feat;
    start_v[idx]    = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    check({tag, "_busy_after_accept"}, int'(busy_v[idx]), 1);
    while (cycles < 200 && !got) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == alt_at) begin
        features_v[idx] = ~feat;
        start_v[idx]    = 1'b1;
      end else if (cycles == alt_at + 1) begin
        start_v[idx] = 1'b0;
      end
      if (cycles == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check({tag, "_busy_after_rst"}, int'(busy_v[idx]), 0);
        for (int k = 0; k < 60; k++) begin
          @(posedge clk); #1;
          if (done_v[idx]) dones++;
        end
        check({tag, "_no_done_after_rst"}, dones, 0);
        check({tag, "_pred_after_rst"}, int'(pred_v[idx]), 0);
        $display("[TB] %s: aborted by reset at busy cycle %0d", tag, rst_at);
        return;
      end
      if (done_v[idx]) got = 1;
    end
    check({tag, "_latency"}, cycles, LATENCY);
    check({tag, "_pred"}, int'(pred_v[idx]), exp_pred);
    check({tag, "_busy_in_done"}, int'(busy_v[idx]), 0);
    @(posedge clk); #1;
    check({tag, "_done_pulse_width"}, int'(done_v[idx]), 0);
    $display("[TB] %s: done after %0d cycles, prediction %0d", tag, cycles,
             pred_v[idx]);
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      start_v[k]    = 1'b0;
      features_v[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("reset_busy_%0d", k), int'(busy_v[k]), 0);
      check($sformatf("reset_done_%0d", k), int'(done_v[k]), 0);
      check($sformatf("reset_pred_%0d", k), int'(pred_v[k]), 0);
    end

    // start coinciding with reset must be ignored
    @(negedge clk);
    start_v[0]    = 1'b1;
    features_v[0] = '1;
    @(posedge clk); #1;
    rst        = 1'b0;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    check("start_with_rst_ignored", int'(busy_v[0]), 0);
    $display("[TB] start_with_rst: busy %0d", busy_v[0]);

    run_one("all_ones",      0, '1, 0, -1, -1);
    run_one("row3_wins",     1, '1, 3, -1, -1);
    run_one("tie_2_4",       2, '1, 2, -1, -1);
    run_one("zero_feat_r5",  3, '0, 5, -1, -1);
    run_one("start_ignored", 1, '1, 3, 10, -1);
    run_one("rst_mid",       1, '1, 3, -1, 20);
    run_one("after_rst",     1, '1, 3, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
